// File: rtl/xnor_test_pkg.sv
// Shared types and defaults for the XNOR cell sweep checker.
package xnor_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    localparam int unsigned DEFAULT_N_IN = 3;
    localparam int unsigned DEFAULT_HOLD = 5;

endpackage

// File: rtl/xnor_sweep_checker_hold_timer.sv
// Hold counter: counts clocks a vector has been applied, wraps after the terminal count.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count marks the last clock of a hold, i.e. the sample cycle.
    assign tc_c = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Next count: clear wins, otherwise advance and wrap on terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xnor_sweep_checker.sv
// Exhaustive stimulus and self-check stage for an N-input XNOR cell.
module xnor_sweep_checker
    import xnor_test_pkg::*;
#(
    parameter int unsigned N_IN        = DEFAULT_N_IN,
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned ERR_W = N_IN + 1;

    sweep_state_e state_q;
    sweep_state_e state_d;

    logic [N_IN-1:0]  vec_d;
    logic             busy_d;
    logic             done_d;
    logic             pass_d;
    logic [ERR_W-1:0] err_d;
    logic             fev_d;
    logic [N_IN-1:0]  fvec_d;

    logic             tc_c;
    logic             accept_c;
    logic             sample_c;
    logic             last_c;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_next_c;

    // Start is honoured only outside a sweep; sampling happens on the hold terminal count.
    assign accept_c   = start && (state_q != DRIVE);
    assign sample_c   = (state_q == DRIVE) && tc_c;
    assign last_c     = (vec_out == {N_IN{1'b1}});
    assign mismatch_c = (dut_f != ~^vec_out);
    assign err_next_c = err_count + ERR_W'(mismatch_c);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .en    (state_q == DRIVE),
        .tc_c  (tc_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (sample_c && last_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs: launch, score each sample, finish.
    always_comb begin
        vec_d  = vec_out;
        busy_d = busy;
        done_d = done;
        pass_d = pass;
        err_d  = err_count;
        fev_d  = first_err_valid;
        fvec_d = first_err_vec;
        if (accept_c) begin
            vec_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
            err_d  = '0;
            fev_d  = 1'b0;
            fvec_d = '0;
        end else if (sample_c) begin
            err_d = err_next_c;
            if (mismatch_c && !first_err_valid) begin
                fev_d  = 1'b1;
                fvec_d = vec_out;
            end
            if (!last_c) begin
                vec_d = vec_out + N_IN'(1);
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_next_c == '0);
            end
        end
    end

    // Output registers; reset aborts a sweep and discards partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            vec_out         <= vec_d;
            busy            <= busy_d;
            done            <= done_d;
            pass            <= pass_d;
            err_count       <= err_d;
            first_err_valid <= fev_d;
            first_err_vec   <= fvec_d;
        end
    end

endmodule

// File: doc/xnor_sweep_checker.md
Name: xnor_sweep_checker

Overview:
- Upstream stimulus and self-check stage for the 3-input XNOR cell (inputs a, b, c; output f).
- On start, drives every input combination onto a/b/c in ascending order (000 to 111, a is the MSB) and holds each vector for HOLD_CYCLES clocks.
- Samples the cell's f at the end of each hold and compares it with the golden value, the reduction XNOR of the vector.
- Reports the mismatch count, the first failing vector, and pass/done flags, so lab bring-up runs exhaustive checks in hardware without a simulator.

Parameters:
- N_IN, default 3: number of cell inputs swept; legal range 2..8.
- HOLD_CYCLES, default 5: clocks each vector is held (50 ns at 10 ns clock); legal minimum 1.
- CNT_W, default $clog2(HOLD_CYCLES)+1: width of the hold counter, derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin a sweep; sampled on clk
- dut_f  in  1  output of the cell under test
- vec_out  out  N_IN  drives cell inputs; for N_IN=3: vec_out[2]=a, [1]=b, [0]=c
- busy  out  1  sweep in progress
- done  out  1  sweep complete; level, held until the next accepted start
- pass  out  1  done and err_count==0
- err_count  out  N_IN+1  number of mismatching vectors; cannot overflow
- first_err_valid  out  1  at least one mismatch recorded
- first_err_vec  out  N_IN  vector of the first mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0, state is IDLE, and the hold counter is 0.
- Reset applied mid-sweep aborts immediately. No partial results are retained.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at an edge moves to DRIVE at that edge.
  - vec_out is set to 0, hold_cnt to 0, and busy to 1.
  - err_count, first_err_valid, first_err_vec, done and pass are all cleared at that edge.
- DRIVE:
  - hold_cnt increments each clock.
  - The clock with hold_cnt==HOLD_CYCLES-1 is the sample cycle. dut_f is compared with ~^vec_out, using the current vec_out.
  - On mismatch: err_count+1. If first_err_valid==0, also capture first_err_vec=vec_out and set first_err_valid=1.
  - At the sample edge, if vec_out != all-ones: vec_out+1 and hold_cnt=0.
  - Otherwise: go to DONE, busy=0, done=1, and pass=(final err_count==0), including a mismatch on the last vector.
- DONE:
  - vec_out holds at all-ones; results are stable.
  - start=1 restarts exactly as from IDLE, clearing results on the same edge.
- start while busy=1 is ignored, with no effect on the sweep.
- Latency: with start accepted at edge T, done is visible after edge T + 2^N_IN*HOLD_CYCLES. For defaults that is 40 cycles.
- With HOLD_CYCLES=1, sampling happens on the same cycle the vector is applied; this is valid because the cell is combinational.
- Sampling the final vector and simultaneously going to DONE happen on one edge; there is no extra cycle.
- vec_out is registered and never glitches outside the defined edges.

Decomposition:
- Package xnor_test_pkg:
  - state enum {IDLE, DRIVE, DONE}
  - DEFAULT_N_IN=3
  - DEFAULT_HOLD=5
- Sub-module hold_timer: counter with clear, enable and terminal-count output (tc at HOLD_CYCLES-1). It is instantiated once.
- The golden model is an inline reduction XNOR, not a sub-module.

Test Plan:
1. Defaults, dut_f wired to the real xnor1 on vec_out -> done=1 and busy=0 exactly 40 cycles after the start edge; pass=1, err_count=0, first_err_valid=0; each vector held 5 cycles, sequence 0..7.
2. dut_f tied to 0 -> err_count=4 (vectors 000, 011, 101, 110 mismatch), first_err_vec=000, pass=0, done at cycle 40.
3. dut_f tied to 1 -> err_count=4, first_err_vec=001, pass=0. Then dut_f=~xnor, i.e. XOR3 -> err_count=8, first_err_vec=000.
4. rst_n pulsed low asynchronously (between edges) while vec_out=011 -> all outputs 0 immediately. After release, pulse start -> full clean sweep, pass=1.
5. start re-asserted at cycles 10 and 20 of a sweep -> ignored, done still at cycle 40. start in DONE with a faulty dut -> results cleared on that edge, new err_count reported.
6. HOLD_CYCLES=1, N_IN=2, real 2-input XNOR -> vec_out 00,01,10,11 on consecutive cycles, done 4 cycles after start, pass=1.
